fdivider: RTL and testbench

- Multi-cycle IEEE-754 binary32 divider, z = a / b.
- Inverse-operation companion to the team's binary32 multiplier. It uses the same start-pulse / result-pulse handshake, so both units plug into the same FP datapath sequencer.
- Radix-2 restoring mantissa division, one quotient bit per cycle.
- Round-to-nearest-even, gradual underflow (subnormal inputs and outputs), fixed latency.

---
 rtl/fdivider.sv | 177 +++++++++++++++++
 tb/tb_fdivider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fdivider.sv
// Multi-cycle IEEE-754 binary32 divider (z = a / b), restoring radix-2 mantissa
// division, round-to-nearest-even, subnormal in/out, fixed 32-cycle latency.
module fdivider (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, UNPACK, PREP, DIV, ROUND, PACK} state_t;

  state_t             state_q, state_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic        [31:0] a_q, a_d, b_q, b_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic        [7:0]  xa_q, xa_d, xb_q, xb_d;
  logic        [22:0] fa_q, fa_d, fb_q, fb_d;
  logic        [3:0]  ca_q, ca_d, cb_q, cb_d;   // {nan, inf, zero, sub}
  logic               spec_q, spec_d, sign_q, sign_d;
  logic        [31:0] sval_q, sval_d;
  logic        [23:0] ma_q, ma_d, mb_q, mb_d, mr_q, mr_d;
  logic signed [9:0]  ze_q, ze_d;
  logic        [25:0] rem_q, rem_d;
  logic        [26:0] q_q, q_d;
  logic        [31:0] z_q, z_d;
  logic               ov_q, ov_d, busy_q, busy_d;

  logic        [4:0]  lza, lzb;
  logic signed [9:0]  ea, eb, zr, diff;
  logic        [23:0] mn;
  logic               g, st, ge;
  logic        [5:0]  sh;
  logic        [49:0] wide;
  logic        [24:0] sum;

  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic found;
    lzc24 = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lzc24 = lzc24 + 5'd1;
      end
    end
  endfunction

  always_comb begin
    state_d = state_q; cnt_d = cnt_q;
    a_d = a_q; b_d = b_q;
    sa_d = sa_q; sb_d = sb_q; xa_d = xa_q; xb_d = xb_q; fa_d = fa_q; fb_d = fb_q;
    ca_d = ca_q; cb_d = cb_q;
    spec_d = spec_q; sign_d = sign_q; sval_d = sval_q;
    ma_d = ma_q; mb_d = mb_q; mr_d = mr_q; ze_d = ze_q;
    rem_d = rem_q; q_d = q_q;
    z_d = z_q; ov_d = 1'b0; busy_d = busy_q;
    lza = lzc24({1'b0, fa_q});
    lzb = lzc24({1'b0, fb_q});
    ea = '0; eb = '0; zr = '0; diff = '0; mn = '0; g = 1'b0; st = 1'b0; ge = 1'b0;
    sh = '0; wide = '0; sum = '0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (valid) begin
          a_d = a; b_d = b; busy_d = 1'b1; state_d = UNPACK;
        end
      end
      UNPACK: begin
        sa_d = a_q[31]; xa_d = a_q[30:23]; fa_d = a_q[22:0];
        sb_d = b_q[31]; xb_d = b_q[30:23]; fb_d = b_q[22:0];
        ca_d = {(&a_q[30:23]) && (|a_q[22:0]), (&a_q[30:23]) && !(|a_q[22:0]),
                !(|a_q[30:23]) && !(|a_q[22:0]), !(|a_q[30:23]) && (|a_q[22:0])};
        cb_d = {(&b_q[30:23]) && (|b_q[22:0]), (&b_q[30:23]) && !(|b_q[22:0]),
                !(|b_q[30:23]) && !(|b_q[22:0]), !(|b_q[30:23]) && (|b_q[22:0])};
        state_d = PREP;
      end
      PREP: begin
        sign_d = sa_q ^ sb_q;
        spec_d = 1'b1;
        if (ca_q[3] || cb_q[3])                        sval_d = 32'h7FC00000;
        else if ((ca_q[2] && cb_q[2]) || (ca_q[1] && cb_q[1])) sval_d = 32'h7FC00000;
        else if (ca_q[2])                              sval_d = {sa_q ^ sb_q, 8'hFF, 23'd0};
        else if (cb_q[2])                              sval_d = {sa_q ^ sb_q, 31'd0};
        else if (cb_q[1])                              sval_d = {sa_q ^ sb_q, 8'hFF, 23'd0};
        else if (ca_q[1])                              sval_d = {sa_q ^ sb_q, 31'd0};
        else                                           spec_d = 1'b0;
        ma_d = ca_q[0] ? ({1'b0, fa_q} << lza) : {1'b1, fa_q};
        mb_d = cb_q[0] ? ({1'b0, fb_q} << lzb) : {1'b1, fb_q};
        ea   = ca_q[0] ? (-10'sd126 - $signed({5'd0, lza})) : ($signed({2'b00, xa_q}) - 10'sd127);
        eb   = cb_q[0] ? (-10'sd126 - $signed({5'd0, lzb})) : ($signed({2'b00, xb_q}) - 10'sd127);
        ze_d = ea - eb;
        cnt_d = 5'd0;
        state_d = DIV;
      end
      DIV: begin
        // Count 0 loads the remainder; counts 1..27 each retire one quotient bit.
        if (cnt_q == 5'd0) begin
          rem_d = {2'b00, ma_q};
          q_d   = '0;
        end else begin
          ge    = rem_q >= {2'b00, mb_q};
          q_d   = {q_q[25:0], ge};
          rem_d = (ge ? (rem_q - {2'b00, mb_q}) : rem_q) << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd27) state_d = ROUND;
      end
      ROUND: begin
        st = |rem_q;
        if (q_q[26]) begin
          mn = q_q[26:3]; g = q_q[2]; st = st | (|q_q[1:0]); zr = ze_q;
        end else begin
          mn = q_q[25:2]; g = q_q[1]; st = st | q_q[0];     zr = ze_q - 10'sd1;
        end
        if (zr < -10'sd126) begin
          diff = -10'sd126 - zr;
          sh   = (diff > 10'sd25) ? 6'd25 : diff[5:0];
          wide = {mn, g, 25'd0} >> sh;
          mn   = wide[49:26];
          g    = wide[25];
          st   = st | (|wide[24:0]);
          zr   = -10'sd126;
        end
        sum = {1'b0, mn} + {24'd0, g & (st | mn[0])};
        if (sum[24]) begin
          mr_d = 24'h800000; ze_d = zr + 10'sd1;
        end else begin
          mr_d = sum[23:0];  ze_d = zr;
        end
        state_d = PACK;
      end
      PACK: begin
        if (spec_q)                                z_d = sval_q;
        else if (ze_q > 10'sd127)                  z_d = {sign_q, 8'hFF, 23'd0};
        else if (ze_q == -10'sd126 && !mr_q[23])   z_d = {sign_q, 8'h00, mr_q[22:0]};
        else                                       z_d = {sign_q, ze_q[7:0] + 8'd127, mr_q[22:0]};
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      z_q     <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    a_q <= a_d; b_q <= b_d;
    sa_q <= sa_d; sb_q <= sb_d; xa_q <= xa_d; xb_q <= xb_d; fa_q <= fa_d; fb_q <= fb_d;
    ca_q <= ca_d; cb_q <= cb_d;
    spec_q <= spec_d; sign_q <= sign_d; sval_q <= sval_d;
    ma_q <= ma_d; mb_q <= mb_d; mr_q <= mr_d; ze_q <= ze_d;
    rem_q <= rem_d; q_q <= q_d;
  end

  assign z         = z_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fdivider.sv
// Scoreboard bench for fdivider: expected quotients and completion cycles are
// queued at issue time and checked whenever out_valid pulses.
module tb_fdivider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] z;
  logic        out_valid, busy;

  fdivider dut (
    .clk(clk), .rst(rst), .valid(valid), .a(a), .b(b),
    .z(z), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  int          tq[$];
  logic [31:0] mon_e;
  int          mon_t;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_out_valid cyc=%0d z=%h", cyc, z);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tq.pop_front();
        vectors += 2;
        if (z !== mon_e) begin
          miscompares++;
          $display("FAIL quotient cyc=%0d got=%h want=%h", cyc, z, mon_e);
        end
        if (cyc != mon_t) begin
          miscompares++;
          $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, mon_t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Caller sits just after a clock edge; valid is sampled at the next edge t.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] xz, output int t);
    valid = 1'b1; a = xa; b = xb;
    @(posedge clk); #1;
    t = cyc;
    valid = 1'b0;
    exp_q.push_back(xz);
    tq.push_back(t + 32);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
      exp_q.delete(); tq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 3;
    if (z !== 32'h0)      begin miscompares++; $display("FAIL reset_z got=%h want=0", z); end
    if (out_valid !== 0)  begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 0)       begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int t;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, t);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      vectors += 2;
      if (busy !== 1'b1) begin
        miscompares++; $display("FAIL basic_busy k=%0d got=%b want=1", k, busy);
      end
      if (out_valid !== (k == 32)) begin
        miscompares++; $display("FAIL basic_out_valid k=%0d got=%b want=%b", k, out_valid, k == 32);
      end
    end
    @(posedge clk); #1;
    vectors += 3;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_ov_after got=%b want=0", out_valid); end
    if (z !== 32'h40400000) begin miscompares++; $display("FAIL basic_z_hold got=%h want=40400000", z); end
  endtask

  task automatic test_values();
    logic [31:0] va[14], vb[14], vz[14];
    int t;
    va = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
           32'h7F800000, 32'h40000000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000,
           32'h00000001, 32'h00000003, 32'h00400000, 32'h40C00000};
    vb = '{32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000,
           32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h3F000000, 32'h40000000,
           32'h40000000, 32'h40000000, 32'h3F000000, 32'hC0000000};
    vz = '{32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
           32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7F800000, 32'h00400000,
           32'h00000000, 32'h00000002, 32'h00800000, 32'hC0400000};
    for (int i = 0; i < 14; i++) begin
      issue(va[i], vb[i], vz[i], t);
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int t, t2;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, t);
    repeat (4) @(posedge clk);
    #1;
    valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;  // sampled at t+5, ignored
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, t2);  // sampled at t+33
    vectors++;
    if (t2 != t + 33) begin
      miscompares++; $display("FAIL restart_edge got=%0d want=%0d", t2, t + 33);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    int t;
    valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
    @(posedge clk); #1;
    t = cyc;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors += 3;
    if (z !== 32'h0)     begin miscompares++; $display("FAIL abort_z got=%h want=0", z); end
    if (out_valid !== 0) begin miscompares++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    if (busy !== 0)      begin miscompares++; $display("FAIL abort_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 0) begin miscompares++; $display("FAIL abort_busy_t11 got=%b want=0", busy); end
    issue(32'h40C00000, 32'h40000000, 32'h40400000, t);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
